pu_job_sequencer: RTL and testbench

- Processor-side responder for the job-dispatch and shared-memory protocols in the coprocessor.
- Accepts one (row, col) block-index pair from the main controller via the index_ready/index_ack handshake.
- Requests the shared memory bus through the round-robin arbiter, fetches A(row,k) and B(k,col) blocks into local buffers for every k, and drives the block MAC engine.
- Writes the finished C(row,col) block back to memory, then returns to idle with result_ready high.

---
 rtl/pu_job_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_pu_job_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_job_sequencer.sv
// Per-PU job sequencer: latches one (row, col) block job, fetches A/B block pairs over the shared
// bus for every k, drives the block MAC engine and writes the finished C block back to memory.
module pu_job_sequencer #(
  parameter int unsigned SIZE            = 3,
  parameter int unsigned CELL_WIDTH      = 32,
  parameter int unsigned INDEX_WIDTH     = 8,
  parameter int unsigned MEMORY_SIZE     = 1024,
  parameter int unsigned MEMORY_SIZE_LOG = 10,
  parameter int unsigned A_BASE          = 16,
  parameter int unsigned B_BASE          = 320,
  parameter int unsigned C_BASE          = 624
) (
  input  logic                                in_clk,
  input  logic                                in_reset,
  input  logic [CELL_WIDTH-1:0]               in_config,
  input  logic                                in_index_ready,
  input  logic [INDEX_WIDTH-1:0]              in_row_index,
  input  logic [INDEX_WIDTH-1:0]              in_col_index,
  output logic                                out_index_ack,
  output logic                                out_result_ready,
  output logic                                out_request,
  input  logic                                in_grant,
  output logic                                out_mem_read_en,
  output logic                                out_mem_write_en,
  output logic [MEMORY_SIZE_LOG-1:0]          out_mem_address,
  output logic [SIZE*CELL_WIDTH-1:0]          out_mem_data,
  input  logic [SIZE*CELL_WIDTH-1:0]          in_mem_data,
  output logic [SIZE*SIZE*CELL_WIDTH-1:0]     out_a_block,
  output logic [SIZE*SIZE*CELL_WIDTH-1:0]     out_b_block,
  output logic                                out_mac_start,
  output logic                                out_mac_clear,
  input  logic                                in_mac_done,
  input  logic [SIZE*SIZE*CELL_WIDTH-1:0]     in_c_block
);

  localparam int unsigned RowWidth   = SIZE * CELL_WIDTH;
  localparam int unsigned BlockWidth = SIZE * RowWidth;
  localparam int unsigned CntWidth   = $clog2(SIZE + 1);
  localparam logic [CntWidth-1:0] NumRows = CntWidth'(SIZE);
  localparam logic [CntWidth-1:0] LastRow = CntWidth'(SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetchA,
    StFetchB,
    StMac,
    StWaitMac,
    StWriteC
  } state_e;

  state_e                  state_q, state_d;
  logic [INDEX_WIDTH-1:0]  row_q, row_d, col_q, col_d;
  logic [7:0]              n_q, n_d, k_q, k_d;
  logic [CntWidth-1:0]     cnt_q, cnt_d, prow_q, prow_d;
  logic                    pend_q, pend_d;
  logic [BlockWidth-1:0]   a_q, b_q;
  logic [MEMORY_SIZE_LOG-1:0] a_addr, b_addr, c_addr;

  logic unused_cfg;
  assign unused_cfg = ^in_config[CELL_WIDTH-1:8];

  // Full 32-bit products, wrapped into the memory address space.
  assign a_addr = MEMORY_SIZE_LOG'((A_BASE + (32'(row_q) * 32'(n_q) + 32'(k_q)) * SIZE
                                    + 32'(cnt_q)) % MEMORY_SIZE);
  assign b_addr = MEMORY_SIZE_LOG'((B_BASE + (32'(k_q) * 32'(n_q) + 32'(col_q)) * SIZE
                                    + 32'(cnt_q)) % MEMORY_SIZE);
  assign c_addr = MEMORY_SIZE_LOG'((C_BASE + (32'(row_q) * 32'(n_q) + 32'(col_q)) * SIZE
                                    + 32'(cnt_q)) % MEMORY_SIZE);

  assign out_a_block = a_q;
  assign out_b_block = b_q;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      n_q     <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      prow_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      n_q     <= n_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      prow_q  <= prow_d;
      pend_q  <= pend_d;
    end
  end

  // Read data returns one cycle after the strobe; pend_q/prow_q remember which row it belongs to.
  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      a_q <= '0;
      b_q <= '0;
    end else if (pend_q) begin
      if (state_q == StFetchA) begin
        a_q[prow_q*RowWidth +: RowWidth] <= in_mem_data;
      end else begin
        b_q[prow_q*RowWidth +: RowWidth] <= in_mem_data;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    row_d            = row_q;
    col_d            = col_q;
    n_d              = n_q;
    k_d              = k_q;
    cnt_d            = cnt_q;
    prow_d           = prow_q;
    pend_d           = 1'b0;
    out_index_ack    = 1'b0;
    out_result_ready = 1'b0;
    out_request      = 1'b0;
    out_mem_read_en  = 1'b0;
    out_mem_write_en = 1'b0;
    out_mem_address  = '0;
    out_mem_data     = '0;
    out_mac_start    = 1'b0;
    out_mac_clear    = 1'b0;

    unique case (state_q)
      StIdle: begin
        out_result_ready = 1'b1;
        if (in_index_ready) begin
          out_index_ack = 1'b1;
          row_d         = in_row_index;
          col_d         = in_col_index;
          n_d           = in_config[7:0];
          k_d           = '0;
          cnt_d         = '0;
          if (in_config[7:0] != 8'd0) begin
            state_d = StFetchA;
          end
        end
      end

      StFetchA, StFetchB: begin
        out_request = (cnt_q < NumRows);
        if (out_request && in_grant) begin
          out_mem_read_en = 1'b1;
          out_mem_address = (state_q == StFetchA) ? a_addr : b_addr;
          cnt_d           = cnt_q + 1'b1;
          pend_d          = 1'b1;
          prow_d          = cnt_q;
        end
        if (pend_q && (prow_q == LastRow)) begin
          state_d = (state_q == StFetchA) ? StFetchB : StMac;
          cnt_d   = '0;
        end
      end

      StMac: begin
        out_mac_start = 1'b1;
        out_mac_clear = (k_q == 8'd0);
        state_d       = StWaitMac;
      end

      StWaitMac: begin
        if (in_mac_done) begin
          cnt_d = '0;
          if (k_q == n_q - 8'd1) begin
            state_d = StWriteC;
          end else begin
            k_d     = k_q + 8'd1;
            state_d = StFetchA;
          end
        end
      end

      StWriteC: begin
        out_request = (cnt_q < NumRows);
        if (out_request && in_grant) begin
          out_mem_write_en = 1'b1;
          out_mem_address  = c_addr;
          out_mem_data     = in_c_block[cnt_q*RowWidth +: RowWidth];
          cnt_d            = cnt_q + 1'b1;
          if (cnt_q == LastRow) begin
            state_d = StIdle;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_pu_job_sequencer.sv
// Directed bench for pu_job_sequencer: models a registered round-robin grant, a one-cycle-latency
// memory and a block MAC engine, and checks bus traffic against hand-computed address lists.
module tb_pu_job_sequencer;
  localparam int SIZE = 3;
  localparam int CW   = 32;
  localparam int RW   = SIZE * CW;
  localparam int BW   = SIZE * RW;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] in_config;
  logic          index_ready;
  logic [7:0]    row_index, col_index;
  logic          index_ack, result_ready, request, grant;
  logic          mem_read_en, mem_write_en;
  logic [9:0]    mem_address;
  logic [RW-1:0] mem_wdata, mem_rdata;
  logic [BW-1:0] a_block, b_block, c_block;
  logic          mac_start, mac_clear, mac_done;

  always #5 clk = ~clk;

  pu_job_sequencer dut (
    .in_clk          (clk),
    .in_reset        (rst),
    .in_config       (in_config),
    .in_index_ready  (index_ready),
    .in_row_index    (row_index),
    .in_col_index    (col_index),
    .out_index_ack   (index_ack),
    .out_result_ready(result_ready),
    .out_request     (request),
    .in_grant        (grant),
    .out_mem_read_en (mem_read_en),
    .out_mem_write_en(mem_write_en),
    .out_mem_address (mem_address),
    .out_mem_data    (mem_wdata),
    .in_mem_data     (mem_rdata),
    .out_a_block     (a_block),
    .out_b_block     (b_block),
    .out_mac_start   (mac_start),
    .out_mac_clear   (mac_clear),
    .in_mac_done     (mac_done),
    .in_c_block      (c_block)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] word(input int w);
    logic [RW-1:0] v;
    for (int e = 0; e < SIZE; e++) v[e*CW +: CW] = CW'(w * 16 + e);
    return v;
  endfunction

  // Memory: read data registered, valid the cycle after the strobe.
  always @(posedge clk) begin
    if (mem_read_en) mem_rdata <= word(int'(mem_address));
    else             mem_rdata <= {SIZE{32'hBAD0BAD0}};
  end

  // Registered arbiter; grant held back for hold_req cycles of each request burst.
  int hold_req = 0;
  int req_cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      grant   <= 1'b0;
      req_cyc <= 0;
    end else begin
      req_cyc <= request ? req_cyc + 1 : 0;
      grant   <= request && (req_cyc >= hold_req);
    end
  end

  int mac_delay = 2;
  int mac_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mac_cnt  <= 0;
      mac_done <= 1'b0;
    end else begin
      mac_done <= (mac_cnt == 1);
      if (mac_start)        mac_cnt <= mac_delay;
      else if (mac_cnt > 0) mac_cnt <= mac_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int            rd_log[$];
  int            wr_log[$];
  logic [RW-1:0] wd_log[$];
  logic          clr_log[$];
  logic [BW-1:0] a_log[$];
  logic [BW-1:0] b_log[$];
  int            ack_cnt = 0;
  int            last_wr_cyc = 0;
  logic          grant_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      grant_prev = 1'b0;
    end else begin
      if (!grant)
        check("bus_idle", BW'({mem_read_en, mem_write_en, mem_address, mem_wdata}), '0);
      if (grant && !grant_prev && request)
        check("first_grant", BW'(mem_read_en | mem_write_en), BW'(1));
      if (mem_read_en) rd_log.push_back(int'(mem_address));
      if (mem_write_en) begin
        wr_log.push_back(int'(mem_address));
        wd_log.push_back(mem_wdata);
        last_wr_cyc = cyc;
      end
      if (mac_start) begin
        clr_log.push_back(mac_clear);
        a_log.push_back(a_block);
        b_log.push_back(b_block);
      end
      if (index_ack) ack_cnt++;
      grant_prev = grant;
    end
  end

  int exp_rd[$];
  int exp_wr[$];

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); wd_log.delete();
    clr_log.delete(); a_log.delete(); b_log.delete();
    ack_cnt = 0;
  endtask

  task automatic set_c(input int job);
    for (int e = 0; e < SIZE * SIZE; e++) c_block[e*CW +: CW] = 32'hC000_0000 + CW'(job * 16 + e);
  endtask

  task automatic start_job(input string tag, input int r, input int c, input int n);
    bit seen = 1'b0;
    @(posedge clk); #1;
    clear_logs();
    in_config   = CW'(n);
    row_index   = 8'(r);
    col_index   = 8'(c);
    index_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (index_ack) seen = 1'b1;
    end
    check({tag, "_ack"}, BW'(seen), BW'(1));
    @(posedge clk); #1;
    index_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (result_ready) seen = 1'b1;
    end
    check({tag, "_done"}, BW'(seen), BW'(1));
  endtask

  task automatic check_job(input string tag, input int nmac);
    logic [BW-1:0] ea, eb;
    check({tag, "_nrd"}, BW'(rd_log.size()), BW'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("%s_rd%0d", tag, i), BW'(rd_log[i]), BW'(exp_rd[i]));
    check({tag, "_nmac"}, BW'(clr_log.size()), BW'(nmac));
    for (int m = 0; m < nmac && m < clr_log.size(); m++) begin
      for (int j = 0; j < SIZE; j++) begin
        ea[j*RW +: RW] = word(exp_rd[m*2*SIZE + j]);
        eb[j*RW +: RW] = word(exp_rd[m*2*SIZE + SIZE + j]);
      end
      check($sformatf("%s_clr%0d", tag, m), BW'(clr_log[m]), BW'(m == 0));
      check($sformatf("%s_ablk%0d", tag, m), a_log[m], ea);
      check($sformatf("%s_bblk%0d", tag, m), b_log[m], eb);
    end
    check({tag, "_nwr"}, BW'(wr_log.size()), BW'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++) begin
      check($sformatf("%s_wr%0d", tag, i), BW'(wr_log[i]), BW'(exp_wr[i]));
      check($sformatf("%s_wd%0d", tag, i), BW'(wd_log[i]), BW'(c_block[i*RW +: RW]));
    end
    check({tag, "_ackcnt"}, BW'(ack_cnt), BW'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst = 1'b1; in_config = '0; index_ready = 1'b0; row_index = '0; col_index = '0;
    c_block = '0;
    #12;
    check("rst_ready", BW'(result_ready), BW'(1));
    check("rst_outs", BW'({index_ack, request, mem_read_en, mem_write_en, mac_start, mac_clear}),
          '0);
    check("rst_ablk", a_block, '0);
    @(posedge clk); #1; rst = 1'b0;

    // 1: reset asserted while a fetch burst is in flight
    start_job("t1", 0, 0, 2);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_read_en) seen = 1'b1;
    end
    check("t1_burst", BW'(seen), BW'(1));
    #2 rst = 1'b1;
    #1;
    check("t1_req", BW'(request), BW'(0));
    check("t1_rd", BW'(mem_read_en), BW'(0));
    check("t1_ready", BW'(result_ready), BW'(1));
    @(posedge clk); #1; rst = 1'b0; ack_cnt = 0;
    repeat (5) @(negedge clk);
    check("t1_noack", BW'(ack_cnt), BW'(0));
    check("t1_idle", BW'({request, result_ready}), BW'(2'b01));

    // 2: single k, block (0,0)
    set_c(2);
    exp_rd = '{16, 17, 18, 320, 321, 322};
    exp_wr = '{624, 625, 626};
    start_job("t2", 0, 0, 1);
    wait_idle("t2");
    check_job("t2", 1);

    // 3: N=2, block (1,1)
    set_c(3);
    exp_rd = '{22, 23, 24, 323, 324, 325, 25, 26, 27, 329, 330, 331};
    exp_wr = '{633, 634, 635};
    start_job("t3", 1, 1, 2);
    wait_idle("t3");
    check_job("t3", 2);

    // 4: grant withheld for 5 cycles of every burst
    hold_req = 4;
    set_c(4);
    exp_rd = '{22, 23, 24, 323, 324, 325};
    exp_wr = '{633, 634, 635};
    start_job("t4", 2, 1, 1);
    wait_idle("t4");
    check_job("t4", 1);
    hold_req = 0;

    // 5: index_ready raised during WAIT_MAC is acked only once back in IDLE
    mac_delay = 6;
    set_c(5);
    start_job("t5", 0, 0, 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (mac_start) seen = 1'b1;
    end
    check("t5_mac", BW'(seen), BW'(1));
    @(posedge clk); #1;
    in_config = '0; index_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (index_ack) seen = 1'b1;
    end
    check("t5_ack", BW'(seen), BW'(1));
    check("t5_ready", BW'(result_ready), BW'(1));
    check("t5_nwr", BW'(wr_log.size()), BW'(3));
    check("t5_first_idle", BW'(cyc - last_wr_cyc), BW'(1));
    @(posedge clk); #1; index_ready = 1'b0;
    mac_delay = 2;

    // 6: N=0 is acked but starts no work
    start_job("t6", 3, 3, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("t6_idle%0d", i), BW'({request, result_ready}), BW'(2'b01));
    end
    check("t6_ackcnt", BW'(ack_cnt), BW'(1));
    check("t6_nrd", BW'(rd_log.size()), BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
